fsm_input_conditioner: RTL and testbench

- Upstream stage of the 3-bit command FSM. Takes raw, asynchronous push-button lines and produces that FSM's `user_input` command bus.
- Synchronises and debounces the buttons, validates them as one-hot, and drives a clean registered command.
- Illegal multi-button presses and unused internal state encodings are trapped safely, so the downstream FSM never sees glitches or undefined codes.

---
 rtl/fsm_input_conditioner.sv | 138 +++++++++++++
 tb/tb_fsm_input_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_input_conditioner.sv
// Purpose: sync, debounce and one-hot validate push buttons into a clean 3-bit command for the command FSM.
// Latency: raw_btn change sampled at edge k appears on user_input at edge k+DEB_CYCLES+3 (7 cycles at default).
// Backpressure: none; the downstream FSM must accept every command, and each cmd_valid pulse marks one new command.
module fsm_input_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] raw_btn,
  output logic [2:0] user_input,
  output logic       cmd_valid,
  output logic       err
);

  // Named state codes. The register itself is a plain vector so that the
  // unused codes 101..111 stay representable and can be trapped explicitly.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_PRESS   = 3'b001,
    S_HOLD    = 3'b010,
    S_RELEASE = 3'b011,
    S_ERROR   = 3'b100
  } state_t;

  // Counter saturates at DEB_CYCLES; the accept point is one below that so
  // that the strobe fires exactly once per accepted vector.
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [2:0]       sync_q1;
  logic [2:0]       sync_q2;
  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       state;

  logic             stable;
  logic             cand_none;
  logic             cand_onehot;
  logic             cand_multi;

  // Two-flop synchroniser per button line; sync_q2 is the only copy used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 3'b000;
      sync_q2 <= 3'b000;
    end else begin
      sync_q1 <= raw_btn;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: any change restarts the run, otherwise count up and saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= 3'b000;
      cnt  <= '0;
    end else if (sync_q2 != cand) begin
      cand <= sync_q2;
      cnt  <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt  <= cnt + 1'b1;
    end
  end

  // One-cycle accept strobe for the candidate vector, plus its classification.
  assign stable      = (cnt == CNT_LAST) && (sync_q2 == cand);
  assign cand_none   = (cand == 3'b000);
  assign cand_onehot = $onehot(cand);
  assign cand_multi  = !cand_none && !cand_onehot;

  // Command FSM: outputs are registered from the current state, so every
  // output change lags the state transition that requested it by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      user_input <= 3'b000;
      cmd_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          user_input <= 3'b000;
          err        <= 1'b0;
          if (stable) begin
            if (cand_onehot) begin
              state <= S_PRESS;
            end else if (cand_multi) begin
              state <= S_ERROR;
            end
          end
        end
        S_PRESS: begin
          // cand still equals the accepted vector here: it can only move
          // after a sync change, which takes at least one more edge.
          user_input <= cand;
          cmd_valid  <= 1'b1;
          err        <= 1'b0;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          err <= 1'b0;
          if (stable) begin
            if (cand_none) begin
              state <= S_RELEASE;
            end else if (cand_multi) begin
              state <= S_ERROR;
            end else if (cand != user_input) begin
              // Direct switch to another button without passing through 000.
              state <= S_PRESS;
            end
          end
        end
        S_RELEASE: begin
          user_input <= 3'b000;
          err        <= 1'b0;
          state      <= S_IDLE;
        end
        S_ERROR: begin
          user_input <= 3'b000;
          err        <= 1'b1;
          // Only a clean all-released vector clears the fault.
          if (stable && cand_none) begin
            state <= S_IDLE;
          end
        end
        default: begin
          // Unused codes: silence the outputs and recover on the next edge.
          user_input <= 3'b000;
          err        <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_input_conditioner.sv
module tb_fsm_input_conditioner;

  localparam int DEB  = 4;
  localparam int HLEN = DEB + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw_btn;
  logic [2:0] user_input;
  logic       cmd_valid;
  logic       err;

  always #5 clk = ~clk;

  fsm_input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_btn    (raw_btn),
    .user_input (user_input),
    .cmd_valid  (cmd_valid),
    .err        (err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model. hist[i] is the raw value sampled i edges ago; a vector
  // is accepted once it has been seen on DEB+1 consecutive samples that end
  // two samples back (synchroniser delay) and were preceded by a different one.
  int         hist [HLEN];
  logic [2:0] exp_ui;
  logic       exp_cv;
  logic       exp_err;
  bit         live;
  bit         faulted;
  logic [2:0] cmd;
  bit         pend_press;
  bit         pend_clear;
  logic [2:0] pend_vec;

  logic [2:0] pick_tbl [12] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b011,
                                3'b101, 3'b110, 3'b111, 3'b001, 3'b010, 3'b100};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < HLEN; i++) hist[i] = (i < 3) ? 0 : 8 + i;
    exp_ui = 3'b000; exp_cv = 1'b0; exp_err = 1'b0;
    live = 0; faulted = 0; cmd = 3'b000;
    pend_press = 0; pend_clear = 0; pend_vec = 3'b000;
  endfunction

  function automatic void model_edge(input logic [2:0] v);
    bit         acc;
    logic [2:0] a;
    for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(v);
    // Decisions from the previous edge become visible now.
    exp_cv = 1'b0;
    if (pend_press) begin
      exp_ui = pend_vec;
      exp_cv = 1'b1;
    end else if (pend_clear) begin
      exp_ui = 3'b000;
    end
    pend_press = 0;
    pend_clear = 0;
    exp_err    = faulted;
    acc = (hist[DEB+3] != hist[DEB+2]);
    for (int i = 2; i <= DEB + 2; i++) if (hist[i] != hist[2]) acc = 0;
    if (acc) begin
      a = 3'(hist[2]);
      if (faulted) begin
        if (a == 3'b000) faulted = 0;
      end else if ($countones(a) > 1) begin
        faulted = 1; live = 0; pend_clear = 1;
      end else if (a == 3'b000) begin
        if (live) begin live = 0; pend_clear = 1; end
      end else if (!live || a != cmd) begin
        live = 1; cmd = a; pend_press = 1; pend_vec = a;
      end
    end
  endfunction

  function automatic void model_force();
    exp_ui = 3'b000; exp_cv = 1'b0; exp_err = 1'b0;
    live = 0; faulted = 0; pend_press = 0; pend_clear = 0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_ui"},  user_input, exp_ui);
    check({tag, "_cv"},  cmd_valid,  exp_cv);
    check({tag, "_err"}, err,        exp_err);
  endtask

  // Called just after an edge: drive, take the next edge, then compare.
  task automatic tick(input logic [2:0] v, input string tag);
    raw_btn = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check_outputs(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_async_ui"},  user_input, 3'b000);
    check({tag, "_async_cv"},  cmd_valid,  1'b0);
    check({tag, "_async_err"}, err,        1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int         first;
    int         pulses;
    int         cnt_bad;
    bit         seen_a;
    bit         seen_b;
    logic [2:0] v;
    int         len;

    // Power-up reset.
    rst     = 1'b1;
    raw_btn = 3'b000;
    @(posedge clk);
    #1;
    check("reset_ui",  user_input, 3'b000);
    check("reset_cv",  cmd_valid,  1'b0);
    check("reset_err", err,        1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Single press held: 7-cycle latency, single pulse.
    first = -1; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(3'b001, "t1");
      if (cmd_valid) pulses++;
      if (first < 0 && user_input == 3'b001) first = i;
    end
    check("t1_latency", first - 1, 7);
    check("t1_pulses", pulses, 1);
    for (int i = 0; i < 10; i++) tick(3'b000, "t1_rel");

    // Bounce: 2-cycle toggling must never be accepted.
    pulses = 0; cnt_bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick((i % 4) < 2 ? 3'b001 : 3'b000, "t2");
      if (cmd_valid) pulses++;
      if (user_input != 3'b000) cnt_bad++;
    end
    for (int i = 0; i < 12; i++) begin
      tick(3'b000, "t2_settle");
      if (cmd_valid) pulses++;
      if (user_input != 3'b000) cnt_bad++;
    end
    check("t2_pulses", pulses, 0);
    check("t2_nonzero", cnt_bad, 0);

    // Direct switch 010 -> 100 with no 000 gap.
    pulses = 0; cnt_bad = 0; seen_a = 0; seen_b = 0;
    for (int i = 0; i < 24; i++) begin
      tick(i < 12 ? 3'b010 : 3'b100, "t3");
      if (cmd_valid) pulses++;
      if (user_input == 3'b010) seen_a = 1;
      if (user_input == 3'b100) seen_b = 1;
      if (seen_a && !seen_b && user_input == 3'b000) cnt_bad++;
    end
    check("t3_pulses", pulses, 2);
    check("t3_seen_both", {seen_a, seen_b}, 2'b11);
    check("t3_gap", cnt_bad, 0);
    for (int i = 0; i < 10; i++) tick(3'b000, "t3_rel");

    // Multi-hot press traps in error; one-hot ignored; release clears.
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(3'b011, "t4_multi");
      if (first < 0 && err) first = i;
    end
    check("t4_err_latency", first - 1, 7);
    check("t4_ui_in_err", user_input, 3'b000);
    cnt_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(3'b100, "t4_onehot");
      if (!err || cmd_valid) cnt_bad++;
    end
    check("t4_err_sticky", cnt_bad, 0);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(3'b000, "t4_clear");
      if (first < 0 && !err) first = i;
    end
    check("t4_clear_latency", first - 1, 7);

    // Illegal state code recovers on the next edge with silent outputs.
    for (int i = 0; i < 12; i++) tick(3'b010, "t5_hold");
    check("t5_pre_ui", user_input, 3'b010);
    raw_btn = 3'b010;
    force dut.state = 3'b111;
    #1;
    release dut.state;
    @(posedge clk);
    model_edge(3'b010);
    model_force();
    #1;
    check_outputs("t5_forced");
    for (int i = 0; i < 10; i++) tick(3'b010, "t5_after");
    for (int i = 0; i < 10; i++) tick(3'b000, "t5_rel");

    // Reset while a button is held: fresh press after full latency.
    for (int i = 0; i < 12; i++) tick(3'b001, "t6_hold");
    check("t6_pre_ui", user_input, 3'b001);
    pulse_reset("t6");
    first = -1; pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(3'b001, "t6_after");
      if (cmd_valid) pulses++;
      if (first < 0 && user_input == 3'b001) first = i;
    end
    check("t6_latency", first - 1, 7);
    check("t6_pulses", pulses, 1);
    for (int i = 0; i < 10; i++) tick(3'b000, "t6_rel");

    // Randomised segments against the model, with one reset in the middle.
    for (int s = 0; s < 60; s++) begin
      v   = pick_tbl[$urandom_range(0, 11)];
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) tick(v, "rnd");
      if (s == 30) pulse_reset("rnd");
    end
    for (int i = 0; i < 12; i++) tick(3'b000, "rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
